// File: rtl/us_sensor_pkg.sv
// Shared definitions for the ultrasonic sensor path: state type and the
// distance/echo constants common with the measurement side.
package us_sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG_HI,
    ST_BURST,
    ST_ECHO,
    ST_HOLDOFF
  } us_state_e;

  localparam int unsigned DEF_CYC_PER_CM  = 58;
  localparam int unsigned DEF_MAX_CM      = 400;
  localparam int unsigned DEF_TIMEOUT_CYC = 38000;

endpackage

// File: rtl/us_pulse_qualifier.sv
// Trigger front end: rising-edge detect and saturating high-width count,
// reporting accept / too_short when the pulse ends while tracked.
module us_pulse_qualifier #(
  parameter int unsigned TRIG_MIN_CYC = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic track,
  input  logic trig_in,
  output logic rise,
  output logic accept,
  output logic too_short
);

  localparam int unsigned WW = $clog2(TRIG_MIN_CYC + 1);

  logic          trig_d;
  logic [WW-1:0] width;

  assign rise      = trig_in & ~trig_d;
  assign accept    = track & ~trig_in & (width >= WW'(TRIG_MIN_CYC));
  assign too_short = track & ~trig_in & (width <  WW'(TRIG_MIN_CYC));

  // trig_d keeps tracking through a clear so a trigger held across
  // re-enable is not mistaken for a fresh edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_d <= 1'b0;
      width  <= '0;
    end else begin
      trig_d <= trig_in;
      if (clear || !trig_in)
        width <= '0;
      else if (rise)
        width <= WW'(1);
      else if (width != '0 && width < WW'(TRIG_MIN_CYC))
        width <= width + WW'(1);
    end
  end

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style transducer emulator: qualifies the trigger, waits the burst
// delay, then returns an echo whose width encodes the programmed distance.
module ultrasonic_echo_responder
  import us_sensor_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYC = 10,
  parameter int unsigned BURST_CYC    = 20,
  parameter int unsigned CYC_PER_CM   = DEF_CYC_PER_CM,
  parameter int unsigned DIST_W       = 9,
  parameter int unsigned MAX_CM       = DEF_MAX_CM,
  parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int unsigned HOLDOFF_CYC  = 100,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              trig_in,
  input  logic [DIST_W-1:0] distance_cm,
  output logic              echo_out,
  output logic              busy,
  output logic              trig_err,
  output logic              meas_done
);

  if (TRIG_MIN_CYC < 1 || BURST_CYC < 1 || HOLDOFF_CYC < 1 || TIMEOUT_CYC < 1 ||
      longint'(MAX_CM) * longint'(CYC_PER_CM) >= (longint'(1) << CNT_W) ||
      longint'(TIMEOUT_CYC) >= (longint'(1) << CNT_W) ||
      longint'(BURST_CYC)   >= (longint'(1) << CNT_W) ||
      longint'(HOLDOFF_CYC) >= (longint'(1) << CNT_W)) begin : g_param_check
    $error("ultrasonic_echo_responder: parameters do not fit CNT_W");
  end

  us_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] echo_len;
  logic [CNT_W-1:0] echo_len_calc;
  logic             rise, accept, too_short;

  us_pulse_qualifier #(
    .TRIG_MIN_CYC(TRIG_MIN_CYC)
  ) u_qual (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (~enable),
    .track    (state == ST_TRIG_HI),
    .trig_in  (trig_in),
    .rise     (rise),
    .accept   (accept),
    .too_short(too_short)
  );

  always_comb begin
    echo_len_calc = CNT_W'(TIMEOUT_CYC);
    if (distance_cm != '0 && 32'(distance_cm) <= MAX_CM)
      echo_len_calc = CNT_W'(distance_cm) * CNT_W'(CYC_PER_CM);
  end

  assign busy = (state != ST_IDLE);

  // One down-counter serves burst, echo and holdoff: each phase loads N-1
  // and advances when it reaches zero, giving exactly N cycles per phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      echo_len  <= '0;
      echo_out  <= 1'b0;
      trig_err  <= 1'b0;
      meas_done <= 1'b0;
    end else begin
      trig_err  <= 1'b0;
      meas_done <= 1'b0;
      if (!enable) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        echo_out <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) state <= ST_TRIG_HI;
          end
          ST_TRIG_HI: begin
            if (accept) begin
              echo_len <= echo_len_calc;
              cnt      <= CNT_W'(BURST_CYC - 1);
              state    <= ST_BURST;
            end else if (too_short) begin
              trig_err <= 1'b1;
              state    <= ST_IDLE;
            end
          end
          ST_BURST: begin
            if (cnt == '0) begin
              state    <= ST_ECHO;
              echo_out <= 1'b1;
              cnt      <= echo_len - CNT_W'(1);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_ECHO: begin
            if (cnt == '0) begin
              state     <= ST_HOLDOFF;
              echo_out  <= 1'b0;
              meas_done <= 1'b1;
              cnt       <= CNT_W'(HOLDOFF_CYC - 1);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_HOLDOFF: begin
            if (cnt == '0) state <= ST_IDLE;
            else           cnt   <= cnt - CNT_W'(1);
          end
          default: begin
            state    <= ST_IDLE;
            cnt      <= '0;
            echo_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Bench for ultrasonic_echo_responder: timeline reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ultrasonic_echo_responder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       trig_in = 1'b0;
  logic [8:0] distance_cm = '0;
  logic       echo_out, busy, trig_err, meas_done;

  int total = 0;
  int bad = 0;
  longint cyc = 0;

  ultrasonic_echo_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .trig_in    (trig_in),
    .distance_cm(distance_cm),
    .echo_out   (echo_out),
    .busy       (busy),
    .trig_err   (trig_err),
    .meas_done  (meas_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a measurement is a set of absolute cycle marks
  // (echo start, echo end, back-to-idle) fixed when the trigger is accepted.
  function automatic longint len_of(input int d);
    return (d == 0 || d > 400) ? 38000 : d * 58;
  endfunction

  longint mc;
  bit     m_trk, m_act, m_prev, m_err;
  int     m_hi;
  longint m_start, m_end, m_idle;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mc = 0; m_trk = 0; m_act = 0; m_prev = 0; m_err = 0; m_hi = 0;
      m_start = 0; m_end = 0; m_idle = 0;
    end else begin
      mc++;
      m_err = 0;
      if (!enable) begin
        m_trk = 0;
        m_act = 0;
      end else if (m_trk) begin
        if (trig_in) m_hi++;
        else begin
          m_trk = 0;
          if (m_hi >= 10) begin
            m_act   = 1;
            m_start = mc + 20;
            m_end   = m_start + len_of(int'(distance_cm));
            m_idle  = m_end + 100;
          end else m_err = 1;
        end
      end else if ((!m_act || mc - 1 >= m_idle) && trig_in && !m_prev) begin
        m_trk = 1;
        m_hi  = 1;
        m_act = 0;
      end
      m_prev = trig_in;
    end
  end

  logic [3:0] exp_v;
  always @(negedge clk) begin
    exp_v[3] = m_act && mc >= m_start && mc < m_end;
    exp_v[2] = m_trk || (m_act && mc < m_idle);
    exp_v[1] = m_err;
    exp_v[0] = m_act && mc == m_end;
    check("cycle{echo,busy,err,done}", {echo_out, busy, trig_err, meas_done}, exp_v);
  end

  // Event monitor used by the literal checks.
  logic   echo_prev = 1'b0;
  longint rise_cyc = 0, run = 0, last_w = 0;
  int     done_cnt = 0, err_cnt = 0;
  always @(negedge clk) begin
    if (echo_out && !echo_prev) begin rise_cyc = cyc; run = 1; end
    else if (echo_out) run++;
    if (!echo_out && echo_prev) last_w = run;
    if (meas_done) done_cnt++;
    if (trig_err) err_cnt++;
    echo_prev = echo_out;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input int len);
    trig_in = 1'b1;
    step(len);
    trig_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin step(1); n++; end
    check("idle_wait", busy, 0);
  endtask

  task automatic wait_echo(input int budget);
    int n = 0;
    while (!echo_out && n < budget) begin step(1); n++; end
    check("echo_wait", echo_out, 1);
  endtask

  initial begin
    longint f;
    int d0, e0, n;
    #2;
    check("reset_echo", echo_out, 0);
    check("reset_busy", busy, 0);
    check("reset_err", trig_err, 0);
    check("reset_done", meas_done, 0);
    step(2);
    reset_n = 1'b1;
    enable  = 1'b1;
    step(2);

    // Nominal 10 cm measurement
    distance_cm = 10;
    d0 = done_cnt;
    pulse(12);
    f = cyc + 1;
    wait_idle(900);
    check("t1_rise_delay", rise_cyc - f, 20);
    check("t1_width", last_w, 580);
    check("t1_done_pulses", done_cnt - d0, 1);

    // Short trigger
    d0 = done_cnt; e0 = err_cnt;
    pulse(5);
    step(1);
    check("t2_err_pulse", trig_err, 1);
    check("t2_busy_low", busy, 0);
    step(3);
    check("t2_err_count", err_cnt - e0, 1);
    check("t2_no_done", done_cnt - d0, 0);

    // Range boundaries
    distance_cm = 401;
    pulse(12);
    wait_idle(38300);
    check("t3_width_401", last_w, 38000);
    step(2);
    distance_cm = 400;
    pulse(12);
    wait_idle(23500);
    check("t3_width_400", last_w, 23200);
    step(2);

    // Triggers during echo and held across holdoff exit
    distance_cm = 3;
    d0 = done_cnt; e0 = err_cnt;
    pulse(12);
    wait_echo(40);
    step(10);
    pulse(12);
    n = 0;
    while (done_cnt == d0 && n < 400) begin step(1); n++; end
    check("t4_first_done", done_cnt - d0, 1);
    step(50);
    trig_in = 1'b1;
    wait_idle(200);
    step(5);
    check("t4_held_trig_ignored", busy, 0);
    trig_in = 1'b0;
    step(2);
    pulse(12);
    step(1);
    check("t4_fresh_trig_accepted", busy, 1);
    wait_idle(600);
    check("t4_done_total", done_cnt - d0, 2);
    check("t4_no_err", err_cnt - e0, 0);

    // Enable abort mid-echo (0 cm => timeout echo), then async reset mid-echo
    distance_cm = 0;
    d0 = done_cnt;
    pulse(12);
    wait_echo(40);
    step(99);
    check("t5_echo_before_abort", echo_out, 1);
    enable = 1'b0;
    step(1);
    check("t5_abort_echo", echo_out, 0);
    check("t5_abort_busy", busy, 0);
    step(5);
    check("t5_abort_no_done", done_cnt - d0, 0);
    enable = 1'b1;
    step(2);
    distance_cm = 5;
    pulse(12);
    wait_echo(40);
    step(10);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_reset_echo", echo_out, 0);
    check("t5_async_reset_busy", busy, 0);
    step(2);
    reset_n = 1'b1;
    step(2);

    // Distance change after acceptance
    distance_cm = 10;
    pulse(12);
    step(1);
    distance_cm = 50;
    wait_idle(900);
    check("t6_width_latched", last_w, 580);

    // Random traffic against the model
    for (int i = 0; i < 15; i++) begin
      distance_cm = 9'($urandom_range(1, 8));
      pulse(int'($urandom_range(3, 14)));
      if ($urandom_range(0, 2) == 0) begin
        step(int'($urandom_range(5, 60)));
        pulse(int'($urandom_range(2, 12)));
      end
      if ($urandom_range(0, 4) == 0) begin
        step(int'($urandom_range(1, 40)));
        enable = 1'b0;
        step(1);
        enable = 1'b1;
      end
      wait_idle(1500);
      step(int'($urandom_range(1, 5)));
    end

    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
